fix_to_fp_11_14: RTL and testbench



---
 rtl/fp_11_14_pkg.sv | 72 +++++++
 rtl/lzc_n.sv | 27 ++
 rtl/fix_to_fp_11_14.sv | 171 +++++++++++++++++
 tb/tb_fix_to_fp_11_14.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_11_14_pkg.sv
// Shared definitions for the 28-bit FloPoCo 11/14 float format used by the
// ray/box float datapath: field widths, exception codes, field positions and
// small helpers (word packing, less_or_equal compare).
package fp_11_14_pkg;

  localparam int unsigned WE   = 11;
  localparam int unsigned WF   = 14;
  localparam int unsigned BIAS = 1023;
  localparam int unsigned FP_W = WE + WF + 3;

  // Field positions inside a FloPoCo word
  localparam int unsigned EXC_HI  = 27;
  localparam int unsigned EXC_LO  = 26;
  localparam int unsigned SIGN    = 25;
  localparam int unsigned EXP_HI  = 24;
  localparam int unsigned EXP_LO  = 14;
  localparam int unsigned FRAC_HI = 13;
  localparam int unsigned FRAC_LO = 0;

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

  typedef struct packed {
    exc_e            exc;
    logic            sign;
    logic [WE-1:0]   exp;
    logic [WF-1:0]   frac;
  } fp_word_t;

  // Build a normal number from its fields
  function automatic fp_word_t fp_pack(input logic          sign,
                                       input logic [WE-1:0] exp,
                                       input logic [WF-1:0] frac);
    fp_word_t w;
    w.exc  = EXC_NORMAL;
    w.sign = sign;
    w.exp  = exp;
    w.frac = frac;
    return w;
  endfunction

  // a <= b; any NaN operand compares false, +0 and -0 are equal.
  // {exc, exp, frac} orders zero < normal < inf, so magnitudes compare as
  // plain unsigned once zero payloads are forced to 0.
  function automatic logic fp_less_or_equal(input fp_word_t a,
                                            input fp_word_t b);
    logic [WE+WF+1:0] mag_a;
    logic [WE+WF+1:0] mag_b;
    logic             neg_a;
    logic             neg_b;
    logic             le;
    mag_a = (a.exc == EXC_ZERO) ? '0 : {a.exc, a.exp, a.frac};
    mag_b = (b.exc == EXC_ZERO) ? '0 : {b.exc, b.exp, b.frac};
    neg_a = a.sign & (a.exc != EXC_ZERO);
    neg_b = b.sign & (b.exc != EXC_ZERO);
    if ((a.exc == EXC_NAN) || (b.exc == EXC_NAN)) begin
      le = 1'b0;
    end else if (neg_a != neg_b) begin
      le = neg_a;
    end else if (neg_a) begin
      le = (mag_a >= mag_b);
    end else begin
      le = (mag_a <= mag_b);
    end
    return le;
  endfunction

endpackage

// File: rtl/lzc_n.sv
// Parameterised leading-zero counter.
// Ports:
//   in_vec  W-bit vector to scan from the MSB
//   count   number of leading zeros; an all-zero vector gives W
module lzc_n #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] count
);

  logic found;

  // Priority scan from the MSB; first set bit fixes the count
  always_comb begin
    count = CW'(W);
    found = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!found && in_vec[i]) begin
        count = CW'(int'(W) - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fix_to_fp_11_14.sv
// Pipelined signed fixed-point to FloPoCo 11/14 float encoder.
// Three register stages (magnitude, normalise, round/pack), valid/ready on
// both sides, round-to-nearest-even. A word accepted on a clock edge is
// presented on out_valid/out_data after the third edge counting that one.
// Optional feature: define FIX2FP_INEXACT_EN to carry a guard|sticky flag on
// out_inexact; otherwise out_inexact is tied to 0.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   in_valid      input word valid
//   in_ready      combinational: pipeline can advance this cycle
//   in_data       IN_W-bit signed fixed point, FRAC_BITS fractional bits
//   out_valid     output word valid
//   out_ready     downstream accepts output
//   out_data      FloPoCo word {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}
//   out_inexact   rounding discarded nonzero bits
module fix_to_fp_11_14 #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned WE        = 11,
  parameter int unsigned WF        = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WE+WF+2:0]    out_data,
  output logic                out_inexact
);

  import fp_11_14_pkg::BIAS;
  import fp_11_14_pkg::fp_pack;

  localparam int unsigned OUT_W    = WE + WF + 3;
  localparam int unsigned LZ_W     = $clog2(IN_W) + 1;
  localparam int unsigned EXT_W    = IN_W + WF + 1;
  localparam int unsigned EXP_BASE = BIAS + IN_W - 1 - FRAC_BITS;

  // Stage 1: sign / magnitude
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  logic [IN_W-1:0]   s1_mag_q,   s1_mag_d;
  // Stage 2: normalised magnitude / raw exponent
  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q,  s2_sign_d;
  logic [IN_W-1:0]   s2_norm_q,  s2_norm_d;
  logic [WE-1:0]     s2_exp_q,   s2_exp_d;
  // Stage 3: packed output word
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q,  out_data_d;
`ifdef FIX2FP_INEXACT_EN
  logic              out_inexact_q, out_inexact_d;
  logic              inexact_c;
`endif

  logic              en_c;
  logic [LZ_W-1:0]   lz_c;
  logic [EXT_W-1:0]  ext_c;
  logic [WF-1:0]     frac_t_c;
  logic              guard_c;
  logic              sticky_c;
  logic              round_up_c;
  logic [WF:0]       frac_sum_c;
  logic [WE-1:0]     exp_r_c;
  logic [OUT_W-1:0]  word_c;

  // Whole pipeline advances together unless a valid output is stalled
  assign en_c     = out_ready | ~out_valid_q;
  assign in_ready = en_c;

  lzc_n #(
    .W  (IN_W),
    .CW (LZ_W)
  ) u_lzc (
    .in_vec (s1_mag_q),
    .count  (lz_c)
  );

  // Rounding on the normalised magnitude. The leading 1 sits at the MSB and
  // is dropped; zero-padding covers IN_W narrower than the fraction.
  always_comb begin
    ext_c      = {s2_norm_q[IN_W-2:0], (WF+2)'(0)};
    frac_t_c   = ext_c[EXT_W-1 -: WF];
    guard_c    = ext_c[EXT_W-1-WF];
    sticky_c   = |ext_c[EXT_W-2-WF:0];
    round_up_c = guard_c & (sticky_c | frac_t_c[0]);
    frac_sum_c = {1'b0, frac_t_c} + (WF+1)'(round_up_c);
    // Carry-out leaves the fraction at 0 and bumps the exponent
    exp_r_c    = s2_exp_q + WE'(frac_sum_c[WF]);
    // A clear MSB after normalisation means the magnitude was zero
    word_c     = s2_norm_q[IN_W-1]
                 ? OUT_W'(fp_pack(s2_sign_q, exp_r_c, frac_sum_c[WF-1:0]))
                 : '0;
`ifdef FIX2FP_INEXACT_EN
    inexact_c  = guard_c | sticky_c;
`endif
  end

  // Next state for all stages: hold by default, shift when enabled
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_norm_d   = s2_norm_q;
    s2_exp_d    = s2_exp_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef FIX2FP_INEXACT_EN
    out_inexact_d = out_inexact_q;
`endif
    if (en_c) begin
      s1_valid_d  = in_valid;
      s1_sign_d   = in_data[IN_W-1];
      // Unsigned magnitude; -2^(IN_W-1) maps onto its own bit pattern exactly
      s1_mag_d    = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_norm_d   = s1_mag_q << lz_c;
      s2_exp_d    = WE'(EXP_BASE) - WE'(lz_c);
      out_valid_d = s2_valid_q;
      out_data_d  = word_c;
`ifdef FIX2FP_INEXACT_EN
      out_inexact_d = inexact_c;
`endif
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_norm_q   <= '0;
      s2_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FIX2FP_INEXACT_EN
      out_inexact_q <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_norm_q   <= s2_norm_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef FIX2FP_INEXACT_EN
      out_inexact_q <= out_inexact_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef FIX2FP_INEXACT_EN
  assign out_inexact = out_inexact_q;
`else
  assign out_inexact = 1'b0;
`endif

endmodule

// File: tb/tb_fix_to_fp_11_14.sv
// Directed testbench for fix_to_fp_11_14: integer instance (FRAC_BITS=0)
// plus a FRAC_BITS=16 instance sharing the same stimulus.
module tb_fix_to_fp_11_14;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic        out_inexact;

  logic        in_ready_f;
  logic        out_valid_f;
  logic [27:0] out_data_f;
  logic        out_inexact_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fix_to_fp_11_14 #(.IN_W(32), .FRAC_BITS(0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  fix_to_fp_11_14 #(.IN_W(32), .FRAC_BITS(16)) u_frac (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready_f),
    .in_data     (in_data),
    .out_valid   (out_valid_f),
    .out_ready   (out_ready),
    .out_data    (out_data_f),
    .out_inexact (out_inexact_f)
  );

  // Hand-computed vectors (FRAC_BITS=0)
  logic [31:0] vec_in  [8] = '{32'h0000_0000, 32'h8000_0000, 32'h0001_0002,
                               32'h0001_0006, 32'h0001_FFFF, 32'h0000_7FFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFD};
  logic [27:0] vec_exp [8] = '{28'h000_0000, 28'h707_8000, 28'h503_C000,
                               28'h503_C002, 28'h504_0000, 28'h503_7FFF,
                               28'h6FF_C000, 28'h700_2000};
  logic        vec_ix  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inexact flag only exists when the feature is built in
  function automatic logic ix(input logic v);
`ifdef FIX2FP_INEXACT_EN
    return v;
`else
    return v & 1'b0;
`endif
  endfunction

  // One word through an empty pipe; out_valid must rise on the 3rd edge
  task automatic single(input string tag, input logic [31:0] d,
                        input logic [27:0] exp_main, input logic ix_main,
                        input logic [27:0] exp_frac);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_in_ready_f"}, 32'(in_ready_f), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    @(negedge clk);
    check({tag, "_lat1"}, 32'(out_valid), 0);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(out_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_main));
    check({tag, "_inexact"}, 32'(out_inexact), 32'(ix(ix_main)));
    check({tag, "_valid_f"}, 32'(out_valid_f), 1);
    check({tag, "_data_f"}, 32'(out_data_f), 32'(exp_frac));
    check({tag, "_inexact_f"}, 32'(out_inexact_f), 0);
  endtask

  // Stream all vectors back to back; out_ready low for cycles stall_lo..hi
  task automatic run_stream(input string tag, input int stall_lo,
                            input int stall_hi);
    int          idx;
    int          cyc;
    int          nout;
    logic        stalled;
    logic [27:0] held;
    logic [27:0] got_d [8];
    logic        got_x [8];
    idx = 0; cyc = 0; nout = 0; stalled = 1'b0; held = '0;
    while ((idx < 8 || nout < 8) && cyc < 100) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      in_valid  = (idx < 8);
      in_data   = (idx < 8) ? vec_in[idx] : 32'h0;
      @(negedge clk);
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(out_valid), 1);
        check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      end
      if (!out_ready) check({tag, "_stall_in_ready"}, 32'(in_ready), 0);
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready && nout < 8) begin
        got_d[nout] = out_data;
        got_x[nout] = out_inexact;
        nout++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    check({tag, "_count"}, 32'(nout), 8);
    for (int i = 0; i < nout; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(vec_exp[i]));
      check($sformatf("%s_inexact%0d", tag, i), 32'(got_x[i]),
            32'(ix(vec_ix[i])));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_inexact", 32'(out_inexact), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);

    // Exact values and the fractional instance
    single("one", 32'h0000_0001, 28'h4FF_C000, 1'b0, 28'h4FB_C000);
    single("one_half", 32'h0001_8000, 28'h503_E000, 1'b0, 28'h4FF_E000);

    // Back-to-back stream, then the same stream with a stall window
    run_stream("stream", -1, -2);
    run_stream("bp", 4, 7);

    // Reset with three words in flight
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    @(posedge clk); #1 in_data = 32'h0000_0002;
    @(posedge clk); #1 in_data = 32'h0000_0003;
    @(posedge clk); #1 in_valid = 1'b0;
    in_data = 32'h0;
    check("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_data", 32'(out_data), 0);
    @(negedge clk); #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("no_stale%0d", i), 32'(out_valid), 0);
    end
    single("after_rst", 32'h0000_0001, 28'h4FF_C000, 1'b0, 28'h4FB_C000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
